clint_mh: RTL and testbench

- Multi-hart core-local interruptor; successor to the single-hart timer block.
- Provides one 64-bit mtime with programmable tick prescaler and freeze input, per-hart mtimecmp and msip registers, and per-hart registered timer/software interrupt outputs.
- APB slave with one wait state, byte strobes and error response; sits on the peripheral APB beside the PLIC and feeds each hart's mip.MTIP/MSIP.

---
 rtl/clint_mh_pkg.sv | 20 ++
 rtl/clint_mh_if.sv | 20 ++
 rtl/clint_mh_timebase.sv | 40 ++++
 rtl/clint_mh.sv | 118 +++++++++++
 tb/tb_clint_mh.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/clint_mh_pkg.sv
// Shared constants and helpers for the multi-hart CLINT: register map offsets,
// APB FSM states and the byte-strobe merge used by every strobed register.
package clint_mh_pkg;

   localparam logic [15:0] MSIP_BASE     = 16'h0000;
   localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
   localparam logic [15:0] MTIME_LO      = 16'hBFF8;
   localparam logic [15:0] MTIME_HI      = 16'hBFFC;

   typedef enum logic {IDLE, RESP} apb_state_t;

   function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      strb_merge = old_val;
      for (int b = 0; b < 4; b++)
         if (strb[b]) strb_merge[8*b +: 8] = new_val[8*b +: 8];
   endfunction

endpackage

// File: rtl/clint_mh_if.sv
// APB bus bundle between the peripheral bridge (master) and the CLINT (slave).
interface clint_mh_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] paddr;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [3:0]            pstrb;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (output paddr, psel, penable, pwrite, pwdata, pstrb,
                   input  prdata, pready, pslverr);
   modport slave  (input  paddr, psel, penable, pwrite, pwdata, pstrb,
                   output prdata, pready, pslverr);
endinterface

// File: rtl/clint_mh_timebase.sv
// 64-bit mtime with a TICK_DIV prescaler and freeze input; a software write
// wins over the same-cycle increment and restarts the prescaler.
module clint_mh_timebase
   import clint_mh_pkg::*;
#(
   parameter int TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        time_en,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   input  logic [3:0]  strb,
   output logic [63:0] mtime
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] presc;
   logic          tick;
   logic          wr;

   // An all-zero strobe is a no-op, so it must not disturb the prescaler either.
   assign wr   = (wr_lo || wr_hi) && (strb != 4'b0000);
   assign tick = time_en && (presc == PW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc <= '0;
         mtime <= '0;
      end else if (wr) begin
         presc <= '0;
         if (wr_lo) mtime[31:0]  <= strb_merge(mtime[31:0],  wdata, strb);
         if (wr_hi) mtime[63:32] <= strb_merge(mtime[63:32], wdata, strb);
      end else if (time_en) begin
         presc <= tick ? '0 : presc + PW'(1);
         if (tick) mtime <= mtime + 64'd1;
      end
   end
endmodule

// File: rtl/clint_mh.sv
// Multi-hart CLINT: APB slave (one wait state) over msip/mtimecmp/mtime with
// registered per-hart timer and software interrupt outputs.
module clint_mh
   import clint_mh_pkg::*;
#(
   parameter int NUM_HARTS  = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int TICK_DIV   = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   clint_mh_if.slave            bus,
   input  logic                 time_en_i,
   output logic [NUM_HARTS-1:0] msip_o,
   output logic [NUM_HARTS-1:0] mtip_o
);
   apb_state_t            state;
   logic [DATA_WIDTH-1:0] prdata_q;
   logic                  pready_q;
   logic                  pslverr_q;

   logic [63:0]          mtimecmp [NUM_HARTS];
   logic [NUM_HARTS-1:0] msip;
   logic [63:0]          mtime;

   logic [ADDR_WIDTH-1:0] addr;
   logic [13:0]           msip_off;
   logic [13:0]           cmp_off;
   logic                  msip_hit, cmp_hit, mlo_hit, mhi_hit, dec_err;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  wr_commit;
   logic                  unused_addr_bits;

   assign addr             = bus.paddr;
   assign unused_addr_bits = ^addr[1:0];

   // Offsets below a region base wrap to large values and fail the range test.
   assign msip_off = addr[15:2] - MSIP_BASE[15:2];
   assign cmp_off  = addr[15:2] - MTIMECMP_BASE[15:2];
   assign msip_hit = msip_off < 14'(NUM_HARTS);
   assign cmp_hit  = cmp_off < 14'(2 * NUM_HARTS);
   assign mlo_hit  = addr[15:2] == MTIME_LO[15:2];
   assign mhi_hit  = addr[15:2] == MTIME_HI[15:2];
   assign dec_err  = !(msip_hit || cmp_hit || mlo_hit || mhi_hit);

   always_comb begin
      rd_data = '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
         if (msip_hit && msip_off[3:0] == 4'(h))
            rd_data = {{(DATA_WIDTH-1){1'b0}}, msip[h]};
         if (cmp_hit && cmp_off[4:1] == 4'(h))
            rd_data = cmp_off[0] ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
      end
      if (mlo_hit) rd_data = mtime[31:0];
      if (mhi_hit) rd_data = mtime[63:32];
   end

   // The error decision latched on entry to RESP gates the commit.
   assign wr_commit = (state == RESP) && bus.psel && bus.penable && bus.pwrite && !pslverr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         msip      <= '0;
         mtip_o    <= '0;
         for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
      end else begin
         for (int h = 0; h < NUM_HARTS; h++) mtip_o[h] <= (mtime >= mtimecmp[h]);
         case (state)
            IDLE: if (bus.psel && bus.penable) begin
               state     <= RESP;
               pready_q  <= 1'b1;
               pslverr_q <= dec_err;
               prdata_q  <= dec_err ? '0 : rd_data;
            end
            RESP: begin
               state     <= IDLE;
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
               prdata_q  <= '0;
            end
            default: state <= IDLE;
         endcase
         if (wr_commit) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
               if (msip_hit && msip_off[3:0] == 4'(h) && bus.pstrb[0])
                  msip[h] <= bus.pwdata[0];
               if (cmp_hit && cmp_off[4:1] == 4'(h)) begin
                  if (cmp_off[0])
                     mtimecmp[h][63:32] <= strb_merge(mtimecmp[h][63:32], bus.pwdata, bus.pstrb);
                  else
                     mtimecmp[h][31:0]  <= strb_merge(mtimecmp[h][31:0],  bus.pwdata, bus.pstrb);
               end
            end
         end
      end
   end

   clint_mh_timebase #(.TICK_DIV(TICK_DIV)) u_timebase (
      .clk     (clk),
      .reset_n (reset_n),
      .time_en (time_en_i),
      .wr_lo   (wr_commit && mlo_hit),
      .wr_hi   (wr_commit && mhi_hit),
      .wdata   (bus.pwdata),
      .strb    (bus.pstrb),
      .mtime   (mtime)
   );

   assign msip_o      = msip;
   assign bus.prdata  = prdata_q;
   assign bus.pready  = pready_q;
   assign bus.pslverr = pslverr_q;
endmodule

// File: tb/tb_clint_mh.sv
// Bench for clint_mh: two instances (TICK_DIV 1 and 4) on one APB driver,
// checked against a cycle-count based model of mtime and the register map.
module tb_clint_mh;
   localparam int NH = 4;

   logic clk, reset_n, time_en;
   int          a_tgt;
   logic [15:0] a_paddr;
   logic        a_psel, a_penable, a_pwrite;
   logic [31:0] a_pwdata;
   logic [3:0]  a_pstrb;
   logic [NH-1:0] msip0, mtip0, msip1, mtip1;

   clint_mh_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus0 ();
   clint_mh_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus1 ();

   assign bus0.paddr = a_paddr;   assign bus1.paddr = a_paddr;
   assign bus0.penable = a_penable; assign bus1.penable = a_penable;
   assign bus0.pwrite = a_pwrite; assign bus1.pwrite = a_pwrite;
   assign bus0.pwdata = a_pwdata; assign bus1.pwdata = a_pwdata;
   assign bus0.pstrb = a_pstrb;   assign bus1.pstrb = a_pstrb;
   assign bus0.psel = a_psel && (a_tgt == 0);
   assign bus1.psel = a_psel && (a_tgt == 1);

   clint_mh #(.NUM_HARTS(NH), .ADDR_WIDTH(16), .DATA_WIDTH(32), .TICK_DIV(1)) u0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0), .time_en_i(time_en), .msip_o(msip0), .mtip_o(mtip0));
   clint_mh #(.NUM_HARTS(NH), .ADDR_WIDTH(16), .DATA_WIDTH(32), .TICK_DIV(4)) u1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1), .time_en_i(time_en), .msip_o(msip1), .mtip_o(mtip1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Model: mtime = value last loaded + (enabled cycles since then) / TICK_DIV.
   longint      en_cnt = 0;
   logic [63:0] m_x [2];
   longint      m_c [2];
   logic [63:0] m_cmp [2][NH];
   logic [NH-1:0] m_msip [2];

   always @(posedge clk) if (reset_n && time_en) en_cnt <= en_cnt + 1;

   function automatic longint td(input int t);
      return (t == 0) ? 1 : 4;
   endfunction

   function automatic logic [63:0] mt_now(input int t);
      return m_x[t] + 64'((en_cnt - m_c[t]) / td(t));
   endfunction

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : o[8*b +: 8];
      return r;
   endfunction

   task automatic model_reset();
      for (int t = 0; t < 2; t++) begin
         m_x[t] = '0; m_c[t] = en_cnt; m_msip[t] = '0;
         for (int h = 0; h < NH; h++) m_cmp[t][h] = '1;
      end
   endtask

   // kind: 0 unmapped, 1 msip, 2/3 mtimecmp lo/hi, 4/5 mtime lo/hi
   function automatic void ref_dec(input logic [15:0] addr, output int kind, output int idx);
      int a;
      a = int'(addr) & 32'hFFFC;
      kind = 0; idx = 0;
      if (a < 4 * NH) begin kind = 1; idx = a / 4; end
      else if (a >= 32'h4000 && a < 32'h4000 + 8 * NH) begin
         idx = (a - 32'h4000) / 8;
         kind = (((a - 32'h4000) % 8) == 0) ? 2 : 3;
      end
      else if (a == 32'hBFF8) kind = 4;
      else if (a == 32'hBFFC) kind = 5;
   endfunction

   function automatic logic [31:0] ref_read(input int t, input int kind, input int idx);
      logic [63:0] v;
      case (kind)
         1: return {31'b0, m_msip[t][idx]};
         2: begin v = m_cmp[t][idx]; return v[31:0]; end
         3: begin v = m_cmp[t][idx]; return v[63:32]; end
         4: begin v = mt_now(t); return v[31:0]; end
         5: begin v = mt_now(t); return v[63:32]; end
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic rdy(input int t);   return t ? bus1.pready  : bus0.pready;  endfunction
   function automatic logic serr(input int t);  return t ? bus1.pslverr : bus0.pslverr; endfunction
   function automatic logic [31:0] prd(input int t); return t ? bus1.prdata : bus0.prdata; endfunction

   task automatic apb(input int t, input logic [15:0] addr, input logic wr, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er);
      int kind, idx;
      logic [31:0] exp_rd;
      logic [63:0] pre, v;
      ref_dec(addr, kind, idx);
      @(negedge clk);
      a_tgt = t; a_paddr = addr; a_pwrite = wr; a_pwdata = d; a_pstrb = s;
      a_psel = 1'b1; a_penable = 1'b0;
      @(negedge clk);
      a_penable = 1'b1;
      exp_rd = ref_read(t, kind, idx);
      @(negedge clk);
      chk("pready_resp", rdy(t), 1'b1);
      chk("pslverr", serr(t), kind == 0);
      chk("prdata", prd(t), exp_rd);
      rd = prd(t); er = serr(t);
      pre = mt_now(t);
      @(posedge clk); #1;
      if (wr && kind != 0) begin
         case (kind)
            1: if (s[0]) m_msip[t][idx] = d[0];
            2: begin v = m_cmp[t][idx]; v[31:0]  = bmerge(v[31:0],  d, s); m_cmp[t][idx] = v; end
            3: begin v = m_cmp[t][idx]; v[63:32] = bmerge(v[63:32], d, s); m_cmp[t][idx] = v; end
            default: if (s != 4'b0) begin
               v = pre;
               if (kind == 4) v[31:0] = bmerge(pre[31:0], d, s);
               else           v[63:32] = bmerge(pre[63:32], d, s);
               m_x[t] = v; m_c[t] = en_cnt;
            end
         endcase
      end
      @(negedge clk);
      a_psel = 1'b0; a_penable = 1'b0;
      chk("pready_idle", rdy(t), 1'b0);
   endtask

   // Continuous interrupt check: mtip follows the previous cycle's compare.
   logic [NH-1:0] exp_mtip [2];
   bit mon_on = 0;
   always @(negedge clk) begin
      if (mon_on) begin
         if (!reset_n) begin
            exp_mtip[0] <= '0; exp_mtip[1] <= '0;
         end else begin
            chk("mtip0", mtip0, exp_mtip[0]);
            chk("mtip1", mtip1, exp_mtip[1]);
            chk("msip0", msip0, m_msip[0]);
            chk("msip1", msip1, m_msip[1]);
            for (int t = 0; t < 2; t++)
               for (int h = 0; h < NH; h++) exp_mtip[t][h] <= (mt_now(t) >= m_cmp[t][h]);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got hang expected finish");
      $fatal(1, "timeout");
   end

   logic [15:0] pool [18] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h4000,
                              16'h4004, 16'h4008, 16'h400C, 16'h4010, 16'h4014, 16'h4018,
                              16'h401C, 16'h4020, 16'hBFF8, 16'hBFFC, 16'h8000, 16'hBFF4};

   initial begin
      logic [31:0] rd;
      logic er;
      reset_n = 1'b0; time_en = 1'b0; a_tgt = 0;
      a_paddr = '0; a_psel = 0; a_penable = 0; a_pwrite = 0; a_pwdata = '0; a_pstrb = '0;
      model_reset();
      exp_mtip[0] = '0; exp_mtip[1] = '0;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;
      mon_on = 1;
      chk("rst_prdata", bus0.prdata, 32'h0);
      chk("rst_pready", bus0.pready, 1'b0);
      chk("rst_pslverr", bus0.pslverr, 1'b0);
      chk("rst_msip", msip0, 4'h0);
      chk("rst_mtip", mtip0, 4'h0);
      time_en = 1'b1;

      apb(0, 16'h4008, 0, 0, 4'hF, rd, er);
      chk("cmp1_reset_rd", rd, 32'hFFFF_FFFF);
      chk("cmp1_reset_err", er, 1'b0);

      apb(0, 16'h0008, 1, 32'h1, 4'hF, rd, er);
      chk("msip2_set", msip0, 4'b0100);
      apb(0, 16'h000C, 1, 32'hFFFF_FFFE, 4'hF, rd, er);
      chk("msip3_bit0_only", msip0, 4'b0100);
      apb(0, 16'h0008, 0, 0, 4'hF, rd, er);
      chk("msip2_rd", rd, 32'h1);

      time_en = 1'b0;
      apb(0, 16'hBFF8, 1, 32'h0, 4'hF, rd, er);
      apb(0, 16'hBFFC, 1, 32'h0, 4'hF, rd, er);
      apb(0, 16'h4008, 1, 32'd20, 4'hF, rd, er);
      apb(0, 16'h400C, 1, 32'h0, 4'hF, rd, er);
      time_en = 1'b1;
      repeat (30) @(negedge clk);
      chk("mtip1_high", mtip0[1], 1'b1);
      chk("mtip0_low", mtip0[0], 1'b0);
      apb(0, 16'h400C, 1, 32'h1, 4'hF, rd, er);
      @(negedge clk);
      chk("mtip1_fall", mtip0[1], 1'b0);

      time_en = 1'b0;
      apb(1, 16'hBFF8, 1, 32'h0, 4'hF, rd, er);
      apb(1, 16'hBFFC, 1, 32'h0, 4'hF, rd, er);
      @(negedge clk); time_en = 1'b1;
      repeat (12) @(negedge clk);
      time_en = 1'b0;
      apb(1, 16'hBFF8, 0, 0, 4'hF, rd, er);
      chk("div4_12cyc", rd, 32'd3);
      repeat (10) @(negedge clk);
      apb(1, 16'hBFF8, 0, 0, 4'hF, rd, er);
      chk("freeze_hold", rd, 32'd3);

      apb(0, 16'hBFFC, 1, 32'h0, 4'hF, rd, er);
      time_en = 1'b1;
      apb(0, 16'hBFF8, 1, 32'h0000_12FC, 4'hF, rd, er);
      apb(0, 16'hBFF8, 1, 32'h0000_00AA, 4'b0001, rd, er);
      time_en = 1'b0;
      apb(0, 16'hBFF8, 0, 0, 4'hF, rd, er);
      chk("strb_lo_preinc", rd, 32'h0000_12AA);

      apb(0, 16'hBFF8, 1, 32'hFFFF_FFFF, 4'hF, rd, er);
      apb(0, 16'hBFFC, 1, 32'hFFFF_FFFF, 4'hF, rd, er);
      @(negedge clk); time_en = 1'b1;
      @(negedge clk); time_en = 1'b0;
      apb(0, 16'hBFF8, 0, 0, 4'hF, rd, er);
      chk("wrap_lo", rd, 32'h0);
      apb(0, 16'hBFFC, 0, 0, 4'hF, rd, er);
      chk("wrap_hi", rd, 32'h0);

      apb(0, 16'h4020, 0, 0, 4'hF, rd, er);
      chk("hart4_err", er, 1'b1);
      chk("hart4_rd0", rd, 32'h0);
      apb(0, 16'h8000, 1, 32'h5555_5555, 4'hF, rd, er);
      chk("unmapped_err", er, 1'b1);
      apb(0, 16'h4020, 1, 32'h0, 4'hF, rd, er);
      apb(0, 16'h4000, 0, 0, 4'hF, rd, er);
      chk("cmp0_untouched", rd, 32'hFFFF_FFFF);

      @(negedge clk);
      a_tgt = 0; a_paddr = 16'h0000; a_pwrite = 1; a_pwdata = 32'h1; a_pstrb = 4'hF;
      a_psel = 1; a_penable = 0;
      @(negedge clk); a_penable = 1;
      @(negedge clk);
      chk("abort_in_resp", bus0.pready, 1'b1);
      #1 reset_n = 1'b0;
      model_reset();
      #1 chk("abort_pready", bus0.pready, 1'b0);
      a_psel = 0; a_penable = 0;
      @(negedge clk); #2 reset_n = 1'b1;
      @(negedge clk);
      chk("abort_msip", msip0, 4'h0);
      apb(0, 16'h0000, 0, 0, 4'hF, rd, er);
      chk("abort_discard", rd, 32'h0);

      for (int i = 0; i < 80; i++) begin
         int t;
         logic [15:0] ad;
         time_en = ($urandom_range(0, 3) != 0);
         t  = $urandom_range(0, 1);
         ad = pool[$urandom_range(0, 17)] | 16'($urandom_range(0, 3));
         apb(t, ad, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), rd, er);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
